cond_exec_stage: RTL and testbench

Execute-stage condition/flags stage of the pipelined core. It sits between the D/E pipeline register and the E/M pipeline register, and owns the architectural 5-bit flags register {S,N,Z,C,V}. Each cycle it evaluates the E-stage condition code against that register, gates the instruction's side effects, and resolves taken branches. It also kills wrong-path instructions in the branch shadow and registers the surviving control and result into the M stage.

---
 rtl/cond_exec_stage_pkg.sv | 34 +++
 rtl/cond_exec_stage_cond_eval.sv | 38 +++
 rtl/cond_exec_stage.sv | 132 +++++++++++++
 tb/tb_cond_exec_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cond_exec_stage_pkg.sv
// Shared definitions for the execute-stage condition/flags logic:
// flag bit positions, condition-code encodings and the shadow state type.
package cond_exec_stage_pkg;

    localparam int FLAGS_WIDTH = 5;
    localparam int FLAG_S      = 4;
    localparam int FLAG_N      = 3;
    localparam int FLAG_Z      = 2;
    localparam int FLAG_C      = 1;
    localparam int FLAG_V      = 0;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    typedef enum logic {
        SHADOW_IDLE   = 1'b0,
        SHADOW_ACTIVE = 1'b1
    } shadow_state_e;

endpackage

// File: rtl/cond_exec_stage_cond_eval.sv
// Combinational condition-code check of one instruction against the flags register.
module cond_eval
    import cond_exec_stage_pkg::*;
(
    input  logic [3:0]             Cond,
    input  logic [FLAGS_WIDTH-1:0] Flags,
    output logic                   pass
);

    logic n, z, c, v;

    always_comb begin
        n = Flags[FLAG_N];
        z = Flags[FLAG_Z];
        c = Flags[FLAG_C];
        v = Flags[FLAG_V];
        pass = 1'b0;
        case (Cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~(c & ~z);
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = ~(~z & (n == v));
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_exec_stage.sv
// Execute-stage flags register, condition gating, taken-branch resolution,
// branch-shadow kill and the E/M pipeline register.
module cond_exec_stage
    import cond_exec_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int BRANCH_SHADOW  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ValidE,
    input  logic [3:0]                CondE,
    input  logic [1:0]                FlagsWriteE,
    input  logic [FLAGS_WIDTH-1:0]    ALUFlagsE,
    input  logic                      RegWriteE,
    input  logic                      MemWriteE,
    input  logic                      MemtoRegE,
    input  logic                      BranchE,
    input  logic [REG_ADDR_WIDTH-1:0] WA3E,
    input  logic [DATA_WIDTH-1:0]     ALUResultE,
    input  logic                      FlagsClear,
    input  logic                      StallE,
    input  logic                      FlushE,
    output logic                      CondExE,
    output logic                      BranchTakenE,
    output logic [FLAGS_WIDTH-1:0]    Flags,
    output logic                      ValidM,
    output logic                      RegWriteM,
    output logic                      MemWriteM,
    output logic                      MemtoRegM,
    output logic [REG_ADDR_WIDTH-1:0] WA3M,
    output logic [DATA_WIDTH-1:0]     ALUResultM
);

    localparam int SHADOW_W = 2;
    localparam logic [SHADOW_W-1:0] SHADOW_LOAD = SHADOW_W'(BRANCH_SHADOW);

    logic [FLAGS_WIDTH-1:0]    flags_q, flags_d;
    logic [SHADOW_W-1:0]       shadow_cnt_q, shadow_cnt_d;
    logic                      valid_m_q, valid_m_d;
    logic                      reg_write_m_q, reg_write_m_d;
    logic                      mem_write_m_q, mem_write_m_d;
    logic                      mem_to_reg_m_q, mem_to_reg_m_d;
    logic [REG_ADDR_WIDTH-1:0] wa3_m_q, wa3_m_d;
    logic [DATA_WIDTH-1:0]     alu_result_m_q, alu_result_m_d;

    shadow_state_e shadow_state;
    logic          cond_pass;
    logic          kill;
    logic          commit;

    cond_eval u_cond_eval (
        .Cond  (CondE),
        .Flags (flags_q),
        .pass  (cond_pass)
    );

    always_comb begin
        shadow_state = (shadow_cnt_q != '0) ? SHADOW_ACTIVE : SHADOW_IDLE;
        kill         = FlushE | (shadow_state == SHADOW_ACTIVE);
        CondExE      = ValidE & ~kill & cond_pass;
        commit       = CondExE & ~StallE;
        BranchTakenE = commit & BranchE;
    end

    always_comb begin
        flags_d = flags_q;
        if (commit && FlagsWriteE[1]) begin
            flags_d[FLAG_N] = ALUFlagsE[FLAG_N];
            flags_d[FLAG_Z] = ALUFlagsE[FLAG_Z];
        end
        if (commit && FlagsWriteE[0]) begin
            flags_d[FLAG_C] = ALUFlagsE[FLAG_C];
            flags_d[FLAG_V] = ALUFlagsE[FLAG_V];
            flags_d[FLAG_S] = flags_q[FLAG_S] | ALUFlagsE[FLAG_S];
        end
        // Saturation clear wins over a same-cycle sticky set, committed or not.
        if (FlagsClear) begin
            flags_d[FLAG_S] = 1'b0;
        end
    end

    always_comb begin
        shadow_cnt_d = shadow_cnt_q;
        if (BranchTakenE) begin
            shadow_cnt_d = SHADOW_LOAD;
        end else if ((shadow_state == SHADOW_ACTIVE) && ValidE && !StallE) begin
            shadow_cnt_d = shadow_cnt_q - 1'b1;
        end
    end

    always_comb begin
        valid_m_d      = commit;
        reg_write_m_d  = commit & RegWriteE & ~BranchE;
        mem_write_m_d  = commit & MemWriteE;
        mem_to_reg_m_d = commit & MemtoRegE;
        wa3_m_d        = commit ? WA3E : wa3_m_q;
        alu_result_m_d = commit ? ALUResultE : alu_result_m_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q        <= '0;
            shadow_cnt_q   <= '0;
            valid_m_q      <= 1'b0;
            reg_write_m_q  <= 1'b0;
            mem_write_m_q  <= 1'b0;
            mem_to_reg_m_q <= 1'b0;
            wa3_m_q        <= '0;
            alu_result_m_q <= '0;
        end else begin
            flags_q        <= flags_d;
            shadow_cnt_q   <= shadow_cnt_d;
            valid_m_q      <= valid_m_d;
            reg_write_m_q  <= reg_write_m_d;
            mem_write_m_q  <= mem_write_m_d;
            mem_to_reg_m_q <= mem_to_reg_m_d;
            wa3_m_q        <= wa3_m_d;
            alu_result_m_q <= alu_result_m_d;
        end
    end

    assign Flags      = flags_q;
    assign ValidM     = valid_m_q;
    assign RegWriteM  = reg_write_m_q;
    assign MemWriteM  = mem_write_m_q;
    assign MemtoRegM  = mem_to_reg_m_q;
    assign WA3M       = wa3_m_q;
    assign ALUResultM = alu_result_m_q;

endmodule

// File: tb/tb_cond_exec_stage.sv
// Directed bench for cond_exec_stage: reset, condition gating, sticky S,
// branch shadow, stall/flush interaction.
module tb_cond_exec_stage;

    logic        clk;
    logic        reset;
    logic        ValidE;
    logic [3:0]  CondE;
    logic [1:0]  FlagsWriteE;
    logic [4:0]  ALUFlagsE;
    logic        RegWriteE, MemWriteE, MemtoRegE, BranchE;
    logic [3:0]  WA3E;
    logic [31:0] ALUResultE;
    logic        FlagsClear, StallE, FlushE;
    logic        CondExE, BranchTakenE;
    logic [4:0]  Flags;
    logic        ValidM, RegWriteM, MemWriteM, MemtoRegM;
    logic [3:0]  WA3M;
    logic [31:0] ALUResultM;

    int vec_cnt = 0;
    int err_cnt = 0;

    cond_exec_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(4), .BRANCH_SHADOW(1)) dut (
        .clk(clk), .reset(reset), .ValidE(ValidE), .CondE(CondE),
        .FlagsWriteE(FlagsWriteE), .ALUFlagsE(ALUFlagsE), .RegWriteE(RegWriteE),
        .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE), .BranchE(BranchE),
        .WA3E(WA3E), .ALUResultE(ALUResultE), .FlagsClear(FlagsClear),
        .StallE(StallE), .FlushE(FlushE), .CondExE(CondExE),
        .BranchTakenE(BranchTakenE), .Flags(Flags), .ValidM(ValidM),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
        .WA3M(WA3M), .ALUResultM(ALUResultM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ValidE = 0; CondE = 4'b1110; FlagsWriteE = 2'b00; ALUFlagsE = 5'b00000;
        RegWriteE = 0; MemWriteE = 0; MemtoRegE = 0; BranchE = 0;
        WA3E = 4'h0; ALUResultE = 32'h0; FlagsClear = 0; StallE = 0; FlushE = 0;
    endtask

    task automatic drive_instr(input logic [3:0] cond, input logic [1:0] fw,
                               input logic [4:0] af, input logic rw, input logic br,
                               input logic [3:0] wa, input logic [31:0] res);
        drive_idle();
        ValidE = 1; CondE = cond; FlagsWriteE = fw; ALUFlagsE = af;
        RegWriteE = rw; BranchE = br; WA3E = wa; ALUResultE = res;
    endtask

    task automatic test_reset();
        drive_instr(4'b1110, 2'b11, 5'b11111, 1, 0, 4'hF, 32'hFFFF_FFFF);
        MemWriteE = 1; MemtoRegE = 1;
        reset = 1;
        tick(); tick();
        vec_cnt++; if (Flags !== 5'b00000) begin err_cnt++; $display("FAIL reset_flags: got %b exp 00000", Flags); end
        vec_cnt++; if ({ValidM, RegWriteM, MemWriteM, MemtoRegM} !== 4'b0000) begin err_cnt++; $display("FAIL reset_ctrl: got %b exp 0000", {ValidM, RegWriteM, MemWriteM, MemtoRegM}); end
        vec_cnt++; if (WA3M !== 4'h0 || ALUResultM !== 32'h0) begin err_cnt++; $display("FAIL reset_data: got %h/%h exp 0/0", WA3M, ALUResultM); end
        reset = 0;
        drive_instr(4'b1110, 2'b00, 5'b00000, 1, 0, 4'h5, 32'h0000_AAAA);
        MemtoRegE = 1;
        #1;
        vec_cnt++; if (CondExE !== 1'b1) begin err_cnt++; $display("FAIL first_al_condex: got %b exp 1", CondExE); end
        tick();
        vec_cnt++; if ({ValidM, RegWriteM, MemWriteM, MemtoRegM} !== 4'b1101) begin err_cnt++; $display("FAIL first_al_ctrl: got %b exp 1101", {ValidM, RegWriteM, MemWriteM, MemtoRegM}); end
        vec_cnt++; if (WA3M !== 4'h5 || ALUResultM !== 32'h0000_AAAA) begin err_cnt++; $display("FAIL first_al_data: got %h/%h exp 5/0000aaaa", WA3M, ALUResultM); end
    endtask

    task automatic test_cmp_cond();
        drive_instr(4'b1110, 2'b11, 5'b00110, 0, 0, 4'h0, 32'h0);
        tick();
        vec_cnt++; if (Flags !== 5'b00110) begin err_cnt++; $display("FAIL cmp_flags: got %b exp 00110", Flags); end
        drive_instr(4'b0000, 2'b00, 5'b00000, 1, 0, 4'h3, 32'h0000_0033);
        #1;
        vec_cnt++; if (CondExE !== 1'b1) begin err_cnt++; $display("FAIL eq_condex: got %b exp 1", CondExE); end
        CondE = 4'b1000; #1;
        vec_cnt++; if (CondExE !== 1'b0) begin err_cnt++; $display("FAIL hi_condex: got %b exp 0", CondExE); end
        CondE = 4'b1010; #1;
        vec_cnt++; if (CondExE !== 1'b1) begin err_cnt++; $display("FAIL ge_condex: got %b exp 1", CondExE); end
        CondE = 4'b1101; #1;
        vec_cnt++; if (CondExE !== 1'b1) begin err_cnt++; $display("FAIL le_condex: got %b exp 1", CondExE); end
        CondE = 4'b0000;
        tick();
        vec_cnt++; if (ValidM !== 1'b1 || WA3M !== 4'h3) begin err_cnt++; $display("FAIL eq_commit: got %b/%h exp 1/3", ValidM, WA3M); end
        drive_instr(4'b0001, 2'b11, 5'b01001, 1, 0, 4'h8, 32'h0000_0088);
        #1;
        vec_cnt++; if (CondExE !== 1'b0) begin err_cnt++; $display("FAIL ne_condex: got %b exp 0", CondExE); end
        tick();
        vec_cnt++; if (ValidM !== 1'b0 || RegWriteM !== 1'b0) begin err_cnt++; $display("FAIL ne_bubble: got %b%b exp 00", ValidM, RegWriteM); end
        vec_cnt++; if (WA3M !== 4'h3 || ALUResultM !== 32'h0000_0033) begin err_cnt++; $display("FAIL ne_hold: got %h/%h exp 3/00000033", WA3M, ALUResultM); end
        vec_cnt++; if (Flags !== 5'b00110) begin err_cnt++; $display("FAIL ne_flags: got %b exp 00110", Flags); end
    endtask

    task automatic test_sticky_s();
        drive_instr(4'b1110, 2'b01, 5'b10000, 0, 0, 4'h0, 32'h0);
        tick();
        vec_cnt++; if (Flags !== 5'b10100) begin err_cnt++; $display("FAIL s_set: got %b exp 10100", Flags); end
        drive_instr(4'b1110, 2'b01, 5'b00000, 0, 0, 4'h0, 32'h0);
        tick();
        vec_cnt++; if (Flags !== 5'b10100) begin err_cnt++; $display("FAIL s_sticky: got %b exp 10100", Flags); end
        drive_instr(4'b1110, 2'b01, 5'b10001, 0, 0, 4'h0, 32'h0);
        FlagsClear = 1;
        tick();
        vec_cnt++; if (Flags !== 5'b00101) begin err_cnt++; $display("FAIL s_clear_prio: got %b exp 00101", Flags); end
        drive_instr(4'b1110, 2'b01, 5'b10000, 0, 0, 4'h0, 32'h0);
        tick();
        drive_idle();
        FlagsClear = 1;
        tick();
        vec_cnt++; if (Flags !== 5'b00100) begin err_cnt++; $display("FAIL s_clear_idle: got %b exp 00100", Flags); end
        drive_idle();
    endtask

    task automatic test_branch();
        drive_instr(4'b1110, 2'b00, 5'b00000, 1, 1, 4'h7, 32'h0000_0100);
        #1;
        vec_cnt++; if (BranchTakenE !== 1'b1) begin err_cnt++; $display("FAIL br_taken: got %b exp 1", BranchTakenE); end
        tick();
        vec_cnt++; if ({ValidM, RegWriteM} !== 2'b10 || ALUResultM !== 32'h0000_0100) begin err_cnt++; $display("FAIL br_m: got %b/%h exp 10/00000100", {ValidM, RegWriteM}, ALUResultM); end
        drive_instr(4'b1110, 2'b11, 5'b01000, 1, 0, 4'h9, 32'h0000_0055);
        #1;
        vec_cnt++; if (CondExE !== 1'b0) begin err_cnt++; $display("FAIL shadow_condex: got %b exp 0", CondExE); end
        tick();
        vec_cnt++; if (ValidM !== 1'b0 || ALUResultM !== 32'h0000_0100) begin err_cnt++; $display("FAIL shadow_m: got %b/%h exp 0/00000100", ValidM, ALUResultM); end
        vec_cnt++; if (Flags !== 5'b00100) begin err_cnt++; $display("FAIL shadow_flags: got %b exp 00100", Flags); end
        drive_instr(4'b1110, 2'b00, 5'b00000, 1, 0, 4'h2, 32'h0000_0077);
        tick();
        vec_cnt++; if ({ValidM, RegWriteM} !== 2'b11 || ALUResultM !== 32'h0000_0077) begin err_cnt++; $display("FAIL post_shadow: got %b/%h exp 11/00000077", {ValidM, RegWriteM}, ALUResultM); end
        // A bubble inside the shadow must not use up the kill slot.
        drive_instr(4'b1110, 2'b00, 5'b00000, 0, 1, 4'h0, 32'h0000_0200);
        tick();
        drive_idle();
        tick();
        drive_instr(4'b1110, 2'b00, 5'b00000, 1, 0, 4'h4, 32'h0000_0044);
        #1;
        vec_cnt++; if (CondExE !== 1'b0) begin err_cnt++; $display("FAIL bubble_no_dec: got %b exp 0", CondExE); end
        tick();
        drive_instr(4'b1110, 2'b00, 5'b00000, 1, 0, 4'h6, 32'h0000_0066);
        #1;
        vec_cnt++; if (CondExE !== 1'b1) begin err_cnt++; $display("FAIL bubble_resume: got %b exp 1", CondExE); end
        tick();
        drive_idle();
    endtask

    task automatic test_stall();
        drive_instr(4'b1110, 2'b11, 5'b01001, 0, 1, 4'h0, 32'h0000_0300);
        StallE = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vec_cnt++; if ({CondExE, BranchTakenE} !== 2'b10) begin err_cnt++; $display("FAIL stall_comb[%0d]: got %b exp 10", i, {CondExE, BranchTakenE}); end
            tick();
            vec_cnt++; if (Flags !== 5'b00100 || ValidM !== 1'b0) begin err_cnt++; $display("FAIL stall_hold[%0d]: got %b/%b exp 00100/0", i, Flags, ValidM); end
        end
        StallE = 0;
        #1;
        vec_cnt++; if (BranchTakenE !== 1'b1) begin err_cnt++; $display("FAIL stall_release: got %b exp 1", BranchTakenE); end
        tick();
        vec_cnt++; if (Flags !== 5'b01001 || ValidM !== 1'b1) begin err_cnt++; $display("FAIL stall_commit: got %b/%b exp 01001/1", Flags, ValidM); end
        drive_instr(4'b1110, 2'b11, 5'b00110, 1, 0, 4'h1, 32'h0000_0011);
        #1;
        vec_cnt++; if ({CondExE, BranchTakenE} !== 2'b00) begin err_cnt++; $display("FAIL stall_shadow: got %b exp 00", {CondExE, BranchTakenE}); end
        tick();
        vec_cnt++; if (Flags !== 5'b01001) begin err_cnt++; $display("FAIL stall_once: got %b exp 01001", Flags); end
        drive_idle();
    endtask

    task automatic test_never_flush();
        drive_instr(4'b1111, 2'b11, 5'b10110, 1, 0, 4'hC, 32'h0000_00CC);
        #1;
        vec_cnt++; if (CondExE !== 1'b0) begin err_cnt++; $display("FAIL nv_condex: got %b exp 0", CondExE); end
        tick();
        vec_cnt++; if (Flags !== 5'b01001 || ValidM !== 1'b0) begin err_cnt++; $display("FAIL nv_effect: got %b/%b exp 01001/0", Flags, ValidM); end
        drive_instr(4'b1110, 2'b00, 5'b00000, 0, 0, 4'hD, 32'h0000_00DD);
        MemWriteE = 1; FlushE = 1;
        #1;
        vec_cnt++; if (CondExE !== 1'b0) begin err_cnt++; $display("FAIL flush_condex: got %b exp 0", CondExE); end
        tick();
        vec_cnt++; if ({ValidM, MemWriteM} !== 2'b00) begin err_cnt++; $display("FAIL flush_store: got %b exp 00", {ValidM, MemWriteM}); end
        // Flush together with stall inside the shadow leaves the counter untouched.
        drive_instr(4'b1110, 2'b00, 5'b00000, 0, 1, 4'h0, 32'h0000_0400);
        tick();
        drive_instr(4'b1110, 2'b00, 5'b00000, 1, 0, 4'hA, 32'h0000_00AA);
        FlushE = 1; StallE = 1;
        tick();
        FlushE = 0; StallE = 0;
        #1;
        vec_cnt++; if (CondExE !== 1'b0) begin err_cnt++; $display("FAIL flush_stall_hold: got %b exp 0", CondExE); end
        tick();
        drive_instr(4'b1110, 2'b00, 5'b00000, 0, 0, 4'h0, 32'h0);
        MemWriteE = 1;
        tick();
        vec_cnt++; if ({ValidM, MemWriteM} !== 2'b11) begin err_cnt++; $display("FAIL store_commit: got %b exp 11", {ValidM, MemWriteM}); end
        drive_idle();
    endtask

    task automatic test_reset_shadow();
        drive_instr(4'b1110, 2'b00, 5'b00000, 0, 1, 4'h0, 32'h0000_0500);
        tick();
        drive_idle();
        reset = 1;
        tick();
        reset = 0;
        drive_instr(4'b1110, 2'b00, 5'b00000, 1, 0, 4'hB, 32'h0000_00BB);
        #1;
        vec_cnt++; if (CondExE !== 1'b1) begin err_cnt++; $display("FAIL reset_shadow_condex: got %b exp 1", CondExE); end
        tick();
        vec_cnt++; if (ValidM !== 1'b1 || WA3M !== 4'hB) begin err_cnt++; $display("FAIL reset_shadow_m: got %b/%h exp 1/b", ValidM, WA3M); end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        reset = 1;
        #1;
        test_reset();
        test_cmp_cond();
        test_sticky_s();
        test_branch();
        test_stall();
        test_never_flush();
        test_reset_shadow();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
